generic_tb_dma32_mem_responder: RTL and testbench
=================================================

// Module: generic_tb_dma32_mem_responder
// PURPOSE
//  Memory-side responder for the 32-bit accelerator DMA interface. It serves dma_read_ctrl/chnl and
//  dma_write_ctrl/chnl requests issued by a generic_tb accelerator from a word-addressed internal memory.
//  Sits in the testbench/system model between the accelerator and DMA; backdoor ports preload/inspect memory.
// PARAMETERS
//  AW     10  log2 of memory depth in 32-bit words (depth = 2**AW)
//  INIT_Z 1   1: memory array not initialised by rst (contents survive reset); 0 reserved
// PORTS
//  clk                         in   1   clock, all logic on rising edge
//  rst                         in   1   reset, asynchronous, active-high
//  dma_read_ctrl_valid         in   1   read request valid
//  dma_read_ctrl_data_index    in   32  start word index
//  dma_read_ctrl_data_length   in   32  beats to return
//  dma_read_ctrl_data_size     in   3   beat size code; 3'b010 (32-bit) is the only legal value
//  dma_read_ctrl_ready         out  1   read request accepted
//  dma_read_chnl_valid         out  1   read data beat valid
//  dma_read_chnl_data          out  32  read data beat
//  dma_read_chnl_ready         in   1   accelerator accepts beat
//  dma_write_ctrl_valid/_data_index/_data_length/_data_size/_ready   as read ctrl, write direction
//  dma_write_chnl_valid        in   1   write data beat valid
//  dma_write_chnl_data         in   32  write data beat
//  dma_write_chnl_ready        out  1   responder accepts beat
//  tb_stall                    in   1   1: force read_chnl_valid=0 and write_chnl_ready=0 (backpressure)
//  bd_we / bd_addr[AW] / bd_wdata[32]   in   backdoor write port
//  bd_raddr [AW] in / bd_rdata [32] out      backdoor async read: bd_rdata = mem[bd_raddr]
//  rd_beats, wr_beats          out  32  completed beat counters
//  size_err                    out  1   sticky: a ctrl request arrived with size != 3'b010
// BEHAVIOUR
//  - Reset (async): state=IDLE, active=0, addr=0, remaining=0, rd_beats=wr_beats=0, size_err=0.
//    All valid/ready outputs 0 while rst=1. Memory contents untouched. active sets 1 on first clk after release.
//  - FSM: IDLE, RD, WR. In IDLE with active=1: read_ctrl_ready=1 and write_ctrl_ready=1; else both 0.
//  - IDLE: if read_ctrl_valid -> handshake read only (read priority on simultaneous requests; write ctrl
//    sees ready but handshake counted only when read_ctrl_valid=0). Capture addr=index[AW-1:0],
//    remaining=length, then go RD. Else if write_ctrl_valid -> same capture, go WR.
//  - length==0: ctrl handshake completes, FSM stays IDLE, no beats.
//  - size!=3'b010 on an accepted request: size_err<=1; request still serviced as 32-bit beats.
//  - RD: read_chnl_valid = !tb_stall; read_chnl_data = mem[addr] (combinational). Beat transfers on
//    valid&&ready: addr<=addr+1 (wraps modulo 2**AW), remaining-1, rd_beats+1. First beat valid the
//    cycle after ctrl handshake. Data/valid stable while valid&&!ready (tb_stall must not drop mid-beat
//    from the bench's side; responder honours it anyway). Last beat -> IDLE next cycle.
//  - WR: write_chnl_ready = !tb_stall. On valid&&ready: mem[addr]<=data, addr+1 (wrap),
//    remaining-1, wr_beats+1. Last beat -> IDLE.
//  - Back-to-back: ctrl ready returns the cycle after the last beat (one IDLE cycle minimum).
//  - Index bits above AW ignored (wrap). remaining is 32-bit; no limit on length other than wrap.
//  - Backdoor write takes effect any cycle; same cycle/same address as a DMA write beat -> DMA data wins.
//  - bd_rdata reflects memory after the clock edge (no read-during-write bypass).
//  - Counters wrap at 2**32. rst asserted mid-transfer aborts it; partial writes stay in memory.
// TESTING
//  1. bd preload mem[0..3]=A0..A3; read idx=0 len=4, chnl_ready=1 -> 4 beats A0..A3 on consecutive
//     cycles, first beat 1 cycle after ctrl handshake, rd_beats=4, FSM IDLE.
//  2. write idx=1020 len=8 (AW=10), data 0..7 -> mem[1020..1023]=0..3, mem[0..3]=4..7, wr_beats=8.
//  3. read len=3 with chnl_ready toggling 1,0,0,1,1 and tb_stall pulse -> data held stable while
//     stalled, exactly 3 beats in order, no duplicates.
//  4. read and write ctrl valid same cycle -> read handshake first; write accepted after read completes.
//  5. ctrl len=0 then size=3'b011 len=1 -> no beats for first, size_err=1, one beat for second.
//  6. rst asserted after 2 of 5 write beats -> outputs 0 immediately, counters 0, mem holds 2 written
//     words; new read after reset returns them.

Source files
------------

// File: rtl/generic_tb_dma32_mem_responder.sv
// Memory-side responder for the 32-bit accelerator DMA interface: serves read/write
// bursts from a word-addressed internal memory, with a backdoor port to preload and inspect it.
module generic_tb_dma32_mem_responder #(
  parameter int AW     = 10,
  parameter int INIT_Z = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dma_read_ctrl_valid,
  input  logic [31:0]   dma_read_ctrl_data_index,
  input  logic [31:0]   dma_read_ctrl_data_length,
  input  logic [2:0]    dma_read_ctrl_data_size,
  output logic          dma_read_ctrl_ready,
  output logic          dma_read_chnl_valid,
  output logic [31:0]   dma_read_chnl_data,
  input  logic          dma_read_chnl_ready,
  input  logic          dma_write_ctrl_valid,
  input  logic [31:0]   dma_write_ctrl_data_index,
  input  logic [31:0]   dma_write_ctrl_data_length,
  input  logic [2:0]    dma_write_ctrl_data_size,
  output logic          dma_write_ctrl_ready,
  input  logic          dma_write_chnl_valid,
  input  logic [31:0]   dma_write_chnl_data,
  output logic          dma_write_chnl_ready,
  input  logic          tb_stall,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_addr,
  input  logic [31:0]   bd_wdata,
  input  logic [AW-1:0] bd_raddr,
  output logic [31:0]   bd_rdata,
  output logic [31:0]   rd_beats,
  output logic [31:0]   wr_beats,
  output logic          size_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  // Memory is never cleared by reset; only INIT_Z=1 is implemented.
  localparam int unused_init_z = INIT_Z;

  logic [1:0]    state;
  logic          active;
  logic [AW-1:0] addr;
  logic [31:0]   remaining;
  logic [31:0]   mem [0:(1<<AW)-1];

  logic ctrl_ready;
  logic rd_hs;
  logic wr_hs;
  logic rd_beat;
  logic wr_beat;
  logic unused_idx_bits;

  assign ctrl_ready           = (state == S_IDLE) && active;
  assign dma_read_ctrl_ready  = ctrl_ready;
  assign dma_write_ctrl_ready = ctrl_ready;

  // Read wins a simultaneous request; the write ctrl stays pending.
  assign rd_hs = ctrl_ready && dma_read_ctrl_valid;
  assign wr_hs = ctrl_ready && dma_write_ctrl_valid && !dma_read_ctrl_valid;

  assign dma_read_chnl_valid  = (state == S_RD) && !tb_stall;
  assign dma_read_chnl_data   = mem[addr];
  assign dma_write_chnl_ready = (state == S_WR) && !tb_stall;

  assign rd_beat = dma_read_chnl_valid && dma_read_chnl_ready;
  assign wr_beat = dma_write_chnl_valid && dma_write_chnl_ready;

  assign bd_rdata = mem[bd_raddr];

  assign unused_idx_bits = ^{dma_read_ctrl_data_index[31:AW], dma_write_ctrl_data_index[31:AW]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      active    <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      rd_beats  <= '0;
      wr_beats  <= '0;
      size_err  <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rd_hs) begin
            addr      <= dma_read_ctrl_data_index[AW-1:0];
            remaining <= dma_read_ctrl_data_length;
            if (dma_read_ctrl_data_size != SIZE_WORD) size_err <= 1'b1;
            if (dma_read_ctrl_data_length != 32'd0) state <= S_RD;
          end else if (wr_hs) begin
            addr      <= dma_write_ctrl_data_index[AW-1:0];
            remaining <= dma_write_ctrl_data_length;
            if (dma_write_ctrl_data_size != SIZE_WORD) size_err <= 1'b1;
            if (dma_write_ctrl_data_length != 32'd0) state <= S_WR;
          end
        end
        S_RD: begin
          if (rd_beat) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 32'd1;
            rd_beats  <= rd_beats + 32'd1;
            if (remaining == 32'd1) state <= S_IDLE;
          end
        end
        S_WR: begin
          if (wr_beat) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 32'd1;
            wr_beats  <= wr_beats + 32'd1;
            if (remaining == 32'd1) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // DMA write is applied after the backdoor so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (wr_beat) mem[addr] <= dma_write_chnl_data;
  end

endmodule

// File: tb/tb_generic_tb_dma32_mem_responder.sv
// Randomized and directed bench for the DMA memory responder, checked every cycle
// against a transaction-level model (memory array, expected read-data queue, counters).
module tb_generic_tb_dma32_mem_responder;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dma_read_ctrl_valid = 1'b0;
  logic [31:0]   dma_read_ctrl_data_index = '0;
  logic [31:0]   dma_read_ctrl_data_length = '0;
  logic [2:0]    dma_read_ctrl_data_size = 3'b010;
  logic          dma_read_ctrl_ready;
  logic          dma_read_chnl_valid;
  logic [31:0]   dma_read_chnl_data;
  logic          dma_read_chnl_ready = 1'b0;
  logic          dma_write_ctrl_valid = 1'b0;
  logic [31:0]   dma_write_ctrl_data_index = '0;
  logic [31:0]   dma_write_ctrl_data_length = '0;
  logic [2:0]    dma_write_ctrl_data_size = 3'b010;
  logic          dma_write_ctrl_ready;
  logic          dma_write_chnl_valid = 1'b0;
  logic [31:0]   dma_write_chnl_data = '0;
  logic          dma_write_chnl_ready;
  logic          tb_stall = 1'b0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_wdata = '0;
  logic [AW-1:0] bd_raddr = '0;
  logic [31:0]   bd_rdata;
  logic [31:0]   rd_beats;
  logic [31:0]   wr_beats;
  logic          size_err;

  generic_tb_dma32_mem_responder #(.AW(AW), .INIT_Z(1)) dut (
    .clk(clk), .rst(rst),
    .dma_read_ctrl_valid(dma_read_ctrl_valid),
    .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
    .dma_read_ctrl_ready(dma_read_ctrl_ready),
    .dma_read_chnl_valid(dma_read_chnl_valid),
    .dma_read_chnl_data(dma_read_chnl_data),
    .dma_read_chnl_ready(dma_read_chnl_ready),
    .dma_write_ctrl_valid(dma_write_ctrl_valid),
    .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
    .dma_write_ctrl_ready(dma_write_ctrl_ready),
    .dma_write_chnl_valid(dma_write_chnl_valid),
    .dma_write_chnl_data(dma_write_chnl_data),
    .dma_write_chnl_ready(dma_write_chnl_ready),
    .tb_stall(tb_stall),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .bd_raddr(bd_raddr), .bd_rdata(bd_rdata),
    .rd_beats(rd_beats), .wr_beats(wr_beats), .size_err(size_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state
  logic [31:0]   mm [DEPTH];
  logic [31:0]   rdq [$];
  logic [31:0]   got_rd [$];
  logic [31:0]   m_rd_cnt = '0;
  logic [31:0]   m_wr_cnt = '0;
  logic [31:0]   m_wr_rem = '0;
  logic [AW-1:0] m_wr_addr = '0;
  logic          m_active = 1'b0;
  logic          m_size_err = 1'b0;
  logic          m_idle;
  logic          mem_ready = 1'b0;
  logic [31:0]   wseq = '0;
  logic          wseq_mode = 1'b0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endfunction

  function automatic void fail_tmo(string nm);
    total++;
    bad++;
    $display("FAIL %s timeout", nm);
  endfunction

  always @(negedge clk) begin
    if (mem_ready) chk("bd_rdata", bd_rdata, mm[bd_raddr]);
    if (rst) begin
      chk("rst_rd_ctrl_ready", {31'd0, dma_read_ctrl_ready}, 32'd0);
      chk("rst_wr_ctrl_ready", {31'd0, dma_write_ctrl_ready}, 32'd0);
      chk("rst_rd_chnl_valid", {31'd0, dma_read_chnl_valid}, 32'd0);
      chk("rst_wr_chnl_ready", {31'd0, dma_write_chnl_ready}, 32'd0);
      chk("rst_rd_beats", rd_beats, 32'd0);
      chk("rst_wr_beats", wr_beats, 32'd0);
      chk("rst_size_err", {31'd0, size_err}, 32'd0);
      rdq.delete();
      m_wr_rem = '0; m_rd_cnt = '0; m_wr_cnt = '0;
      m_active = 1'b0; m_size_err = 1'b0;
      if (bd_we) mm[bd_addr] = bd_wdata;
    end else begin
      m_idle = m_active && rdq.size() == 0 && m_wr_rem == 0;
      chk("rd_ctrl_ready", {31'd0, dma_read_ctrl_ready}, {31'd0, m_idle});
      chk("wr_ctrl_ready", {31'd0, dma_write_ctrl_ready}, {31'd0, m_idle});
      chk("rd_chnl_valid", {31'd0, dma_read_chnl_valid}, {31'd0, rdq.size() != 0 && !tb_stall});
      chk("wr_chnl_ready", {31'd0, dma_write_chnl_ready}, {31'd0, m_wr_rem != 0 && !tb_stall});
      chk("rd_beats", rd_beats, m_rd_cnt);
      chk("wr_beats", wr_beats, m_wr_cnt);
      chk("size_err", {31'd0, size_err}, {31'd0, m_size_err});
      if (rdq.size() != 0 && !tb_stall && dma_read_chnl_ready) begin
        chk("rd_data", dma_read_chnl_data, rdq[0]);
        got_rd.push_back(dma_read_chnl_data);
        void'(rdq.pop_front());
        m_rd_cnt = m_rd_cnt + 32'd1;
      end
      if (bd_we) mm[bd_addr] = bd_wdata;
      if (m_wr_rem != 0 && !tb_stall && dma_write_chnl_valid) begin
        mm[m_wr_addr] = dma_write_chnl_data;
        m_wr_addr = m_wr_addr + 1'b1;
        m_wr_rem = m_wr_rem - 32'd1;
        m_wr_cnt = m_wr_cnt + 32'd1;
      end
      if (m_idle && dma_read_ctrl_valid) begin
        if (dma_read_ctrl_data_size != 3'b010) m_size_err = 1'b1;
        for (int i = 0; i < int'(dma_read_ctrl_data_length); i++)
          rdq.push_back(mm[AW'(dma_read_ctrl_data_index + 32'(i))]);
      end else if (m_idle && dma_write_ctrl_valid) begin
        if (dma_write_ctrl_data_size != 3'b010) m_size_err = 1'b1;
        m_wr_addr = dma_write_ctrl_data_index[AW-1:0];
        m_wr_rem = dma_write_ctrl_data_length;
      end
      m_active = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    dma_read_chnl_ready = 1'b0;
    dma_write_chnl_valid = 1'b0;
    tb_stall = 1'b0;
    bd_we = 1'b0;
  endtask

  task automatic ctrl_req(input bit wr, input logic [31:0] idx, input logic [31:0] len,
                          input logic [2:0] size);
    if (wr) begin
      dma_write_ctrl_data_index = idx; dma_write_ctrl_data_length = len;
      dma_write_ctrl_data_size = size; dma_write_ctrl_valid = 1'b1;
    end else begin
      dma_read_ctrl_data_index = idx; dma_read_ctrl_data_length = len;
      dma_read_ctrl_data_size = size; dma_read_ctrl_valid = 1'b1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dma_read_ctrl_ready) begin
        cyc();
        dma_read_ctrl_valid = 1'b0;
        dma_write_ctrl_valid = 1'b0;
        return;
      end
      cyc();
    end
    fail_tmo("ctrl_handshake");
    dma_read_ctrl_valid = 1'b0;
    dma_write_ctrl_valid = 1'b0;
  endtask

  // Drives channel traffic until the responder is back in IDLE; n counts observed cycles.
  task automatic run_idle(input int rpct, input int vpct, input int spct, input int bdpct,
                          output int n);
    n = 0;
    for (int c = 0; c < 400; c++) begin
      dma_read_chnl_ready = ($urandom_range(99) < rpct);
      dma_write_chnl_valid = ($urandom_range(99) < vpct);
      dma_write_chnl_data = wseq_mode ? wseq : $urandom;
      tb_stall = ($urandom_range(99) < spct);
      bd_we = ($urandom_range(99) < bdpct);
      bd_addr = $urandom_range(1) ? m_wr_addr : AW'($urandom);
      bd_wdata = $urandom;
      bd_raddr = AW'($urandom);
      @(negedge clk);
      n++;
      if (dma_write_chnl_valid && dma_write_chnl_ready) wseq = wseq + 32'd1;
      if (dma_read_ctrl_ready) begin
        cyc();
        quiet();
        return;
      end
      cyc();
    end
    fail_tmo("run_idle");
    quiet();
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    cyc();
    bd_we = 1'b0;
  endtask

  task automatic bd_check(string nm, input logic [AW-1:0] a, input logic [31:0] d);
    bd_raddr = a;
    @(negedge clk);
    chk(nm, bd_rdata, d);
    cyc();
  endtask

  initial begin
    int n;
    int k;
    bit rp [7];
    bit sp [7];
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    cyc();
    for (int i = 0; i < DEPTH; i++) bd_write(AW'(i), $urandom);
    mem_ready = 1'b1;
    rst = 1'b0;
    cyc();

    // 1: preload and 4-beat read with full readiness
    for (int i = 0; i < 4; i++) bd_write(AW'(i), 32'hA0 + 32'(i));
    got_rd.delete();
    ctrl_req(1'b0, 32'd0, 32'd4, 3'b010);
    run_idle(100, 0, 0, 0, n);
    chk("t1_cycles", 32'(n), 32'd5);
    chk("t1_count", 32'(got_rd.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (got_rd.size() > i) chk("t1_data", got_rd[i], 32'hA0 + 32'(i));
    chk("t1_rd_beats", rd_beats, 32'd4);

    // 2: write wrapping past the top of memory
    wseq = '0; wseq_mode = 1'b1;
    ctrl_req(1'b1, 32'd1020, 32'd8, 3'b010);
    run_idle(0, 100, 0, 0, n);
    wseq_mode = 1'b0;
    chk("t2_wr_beats", wr_beats, 32'd8);
    for (int i = 0; i < 8; i++) bd_check("t2_mem", AW'(1020 + i), 32'(i));

    // 3: read with toggling ready and stall pulses
    bd_write(AW'(100), 32'h11); bd_write(AW'(101), 32'h22); bd_write(AW'(102), 32'h33);
    rp = '{1, 0, 0, 1, 1, 1, 1};
    sp = '{0, 0, 1, 0, 1, 0, 0};
    got_rd.delete();
    ctrl_req(1'b0, 32'd100, 32'd3, 3'b010);
    for (int i = 0; i < 7; i++) begin
      dma_read_chnl_ready = rp[i];
      tb_stall = sp[i];
      @(negedge clk);
      if (i == 1) chk("t3_hold_data", dma_read_chnl_data, 32'h22);
      if (i == 2) chk("t3_stall_valid", {31'd0, dma_read_chnl_valid}, 32'd0);
      if (i == 6) chk("t3_idle", {31'd0, dma_read_ctrl_ready}, 32'd1);
      cyc();
    end
    quiet();
    chk("t3_count", 32'(got_rd.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (got_rd.size() > i) chk("t3_data", got_rd[i], 32'h11 * 32'(i + 1));
    chk("t3_rd_beats", rd_beats, 32'd7);

    // 4: simultaneous read and write requests
    dma_read_ctrl_data_index = 32'd200; dma_read_ctrl_data_length = 32'd2;
    dma_read_ctrl_data_size = 3'b010; dma_read_ctrl_valid = 1'b1;
    dma_write_ctrl_data_index = 32'd300; dma_write_ctrl_data_length = 32'd2;
    dma_write_ctrl_data_size = 3'b010; dma_write_ctrl_valid = 1'b1;
    @(negedge clk);
    chk("t4_both_ready", {30'd0, dma_read_ctrl_ready, dma_write_ctrl_ready}, 32'd3);
    cyc();
    dma_read_ctrl_valid = 1'b0;
    run_idle(100, 0, 0, 0, n);
    dma_write_ctrl_valid = 1'b0;
    chk("t4_rd_first", rd_beats, 32'd9);
    chk("t4_wr_pending", wr_beats, 32'd8);
    wseq = '0; wseq_mode = 1'b1;
    run_idle(0, 100, 0, 0, n);
    wseq_mode = 1'b0;
    chk("t4_wr_done", wr_beats, 32'd10);
    bd_check("t4_mem0", AW'(300), 32'd0);
    bd_check("t4_mem1", AW'(301), 32'd1);

    // 5: zero-length request, then an illegal size
    ctrl_req(1'b0, 32'd400, 32'd0, 3'b010);
    run_idle(100, 0, 0, 0, n);
    chk("t5_len0_cycles", 32'(n), 32'd1);
    chk("t5_len0_beats", rd_beats, 32'd9);
    chk("t5_no_err", {31'd0, size_err}, 32'd0);
    ctrl_req(1'b0, 32'd400, 32'd1, 3'b011);
    run_idle(100, 0, 0, 0, n);
    chk("t5_size_err", {31'd0, size_err}, 32'd1);
    chk("t5_beats", rd_beats, 32'd10);

    // 6: reset in the middle of a write burst
    ctrl_req(1'b1, 32'd500, 32'd5, 3'b010);
    k = 0;
    for (int c = 0; c < 50 && k < 2; c++) begin
      dma_write_chnl_valid = 1'b1;
      dma_write_chnl_data = 32'hB0 + 32'(k);
      @(negedge clk);
      if (dma_write_chnl_ready) k++;
      if (k < 2) cyc();
    end
    cyc();
    rst = 1'b1;
    dma_write_chnl_valid = 1'b0;
    @(negedge clk);
    chk("t6_wr_ready", {31'd0, dma_write_chnl_ready}, 32'd0);
    chk("t6_wr_beats", wr_beats, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    got_rd.delete();
    ctrl_req(1'b0, 32'd500, 32'd2, 3'b010);
    run_idle(100, 0, 0, 0, n);
    chk("t6_count", 32'(got_rd.size()), 32'd2);
    for (int i = 0; i < 2; i++)
      if (got_rd.size() > i) chk("t6_data", got_rd[i], 32'hB0 + 32'(i));
    chk("t6_rd_beats", rd_beats, 32'd2);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      bit wr;
      logic [2:0] sz;
      wr = 1'($urandom_range(1));
      sz = ($urandom_range(7) == 0) ? 3'($urandom) : 3'b010;
      ctrl_req(wr, $urandom, 32'($urandom_range(12)), sz);
      run_idle(70, 70, 20, wr ? 30 : 0, n);
      if ($urandom_range(3) == 0) begin
        bd_write(AW'($urandom), $urandom);
        bd_raddr = AW'($urandom);
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
